fault_reporter: RTL and testbench

- Consumer side of the processor's sticky error flag.
- Snoops the same decode/execute fault conditions that set the error flag and latches a cause code plus the faulting PC.
- Asserts halt to freeze the stage sequencer, then streams a fault record byte-by-byte over a valid/ready interface to the debug UART transmitter.
- Holds halt until software or the debugger pulses fault_clear.

---
 rtl/fault_reporter_pkg.sv | 20 ++
 rtl/fault_reporter_if.sv | 11 +
 rtl/fault_cause_encoder.sv | 48 ++++
 rtl/fault_reporter.sv | 149 ++++++++++++++
 tb/tb_fault_reporter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fault_reporter_pkg.sv
// Shared types and constants for the fault reporter: FSM states, cause codes, default sync byte.
package fault_reporter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CAUSE_DECODE      = 8'h01;
    localparam logic [7:0] CAUSE_MULTI_OP    = 8'h02;
    localparam logic [7:0] CAUSE_EXEC_BASE   = 8'h10;
    localparam logic [7:0] CAUSE_UNKNOWN     = 8'hFF;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hFE;

    localparam logic [1:0] STAGE_DECODE      = 2'd2;
    localparam logic [1:0] STAGE_EXECUTE     = 2'd3;

endpackage

// File: rtl/fault_reporter_if.sv
// Byte-stream valid/ready link from the fault reporter to the debug UART transmitter.
interface fault_reporter_if;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/fault_cause_encoder.sv
// Combinational priority encoder turning snooped decode/execute fault conditions into a cause code.
module fault_cause_encoder
    import fault_reporter_pkg::*;
#(
    parameter int unsigned NUM_OPCODES = 11
) (
    input  logic [1:0]             current_pipeline_stage,
    input  logic                   id_opcode_decoding_error,
    input  logic                   error,
    input  logic [NUM_OPCODES-1:0] ex_errors,
    input  logic [NUM_OPCODES-1:0] ex_opcode_selection,
    output logic [7:0]             cause_c,
    output logic                   fault_c
);

    logic [NUM_OPCODES-1:0] hit;
    logic                   multi_sel;
    logic [7:0]             low_idx;

    // Lowest set bit wins, so scan downward and let later hits overwrite.
    always_comb begin
        hit       = ex_errors & ex_opcode_selection;
        multi_sel = (ex_opcode_selection & (ex_opcode_selection - NUM_OPCODES'(1))) != '0;
        low_idx   = '0;
        for (int i = int'(NUM_OPCODES) - 1; i >= 0; i--) begin
            if (hit[i]) low_idx = 8'(i);
        end
    end

    always_comb begin
        cause_c = '0;
        fault_c = 1'b0;
        if (current_pipeline_stage == STAGE_DECODE && id_opcode_decoding_error) begin
            cause_c = CAUSE_DECODE;
            fault_c = 1'b1;
        end else if (current_pipeline_stage == STAGE_EXECUTE && multi_sel) begin
            cause_c = CAUSE_MULTI_OP;
            fault_c = 1'b1;
        end else if (current_pipeline_stage == STAGE_EXECUTE && hit != '0) begin
            cause_c = CAUSE_EXEC_BASE | low_idx;
            fault_c = 1'b1;
        end else if (error) begin
            cause_c = CAUSE_UNKNOWN;
            fault_c = 1'b1;
        end
    end

endmodule

// File: rtl/fault_reporter.sv
// Latches the first fault cause and PC, halts the sequencer and streams a fault record to the UART.
// Optional trailing XOR checksum byte when FAULT_REPORTER_CHECKSUM_EN is defined.
module fault_reporter
    import fault_reporter_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned NUM_OPCODES = 11,
    parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   error,
    input  logic                   id_opcode_decoding_error,
    input  logic [NUM_OPCODES-1:0] ex_errors,
    input  logic [NUM_OPCODES-1:0] ex_opcode_selection,
    input  logic [1:0]             current_pipeline_stage,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic                   fault_clear,
    fault_reporter_if.master       tx,
    output logic                   halt,
    output logic [7:0]             fault_cause
);

    localparam int unsigned PC_BYTES = PC_WIDTH / 8;
    localparam int unsigned MAX_LEN  = 3 + PC_BYTES;
`ifdef FAULT_REPORTER_CHECKSUM_EN
    localparam int unsigned REC_LEN  = 3 + PC_BYTES;
`else
    localparam int unsigned REC_LEN  = 2 + PC_BYTES;
`endif
    localparam int unsigned IDX_W    = $clog2(MAX_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_LEN - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d, idx_nxt;
    logic [7:0]            cause_q, cause_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  halt_q, halt_d;
    logic                  valid_q, valid_d;
    logic [7:0]            data_q, data_d, byte_nxt;
    logic [7:0]            csum_q, csum_d;
    logic [7:0]            cause_c;
    logic                  fault_c;

    fault_cause_encoder #(
        .NUM_OPCODES (NUM_OPCODES)
    ) u_cause_enc (
        .current_pipeline_stage   (current_pipeline_stage),
        .id_opcode_decoding_error (id_opcode_decoding_error),
        .error                    (error),
        .ex_errors                (ex_errors),
        .ex_opcode_selection      (ex_opcode_selection),
        .cause_c                  (cause_c),
        .fault_c                  (fault_c)
    );

    // Byte that follows the one currently on the bus; preloaded so tx_data is a flop.
    always_comb begin
        idx_nxt  = idx_q + IDX_W'(1);
        byte_nxt = '0;
        if (idx_nxt == IDX_W'(1)) byte_nxt = cause_q;
        for (int unsigned k = 0; k < PC_BYTES; k++) begin
            if (idx_nxt == IDX_W'(k + 2)) byte_nxt = pc_q[8*k +: 8];
        end
`ifdef FAULT_REPORTER_CHECKSUM_EN
        if (idx_nxt == LAST_IDX) byte_nxt = csum_q ^ data_q;
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        halt_d  = halt_q;
        valid_d = valid_q;
        data_d  = data_q;
        csum_d  = csum_q;
        case (state_q)
            IDLE: begin
                if (fault_c) begin
                    state_d = SEND;
                    cause_d = cause_c;
                    pc_d    = pc;
                    halt_d  = 1'b1;
                    valid_d = 1'b1;
                    data_d  = SYNC_BYTE;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            SEND: begin
                if (tx.tx_ready) begin
                    csum_d = csum_q ^ data_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        data_d  = '0;
                    end else begin
                        idx_d  = idx_nxt;
                        data_d = byte_nxt;
                    end
                end
            end
            DONE: begin
                if (fault_clear) begin
                    state_d = IDLE;
                    cause_d = '0;
                    halt_d  = 1'b0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                halt_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cause_q <= '0;
            pc_q    <= '0;
            halt_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            halt_q  <= halt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            csum_q  <= csum_d;
        end
    end

    assign tx.tx_valid = valid_q;
    assign tx.tx_data  = data_q;
    assign halt        = halt_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_fault_reporter.sv
// Scoreboard bench for fault_reporter: stimulus queues expected record bytes, a monitor pops on each handshake.
module tb_fault_reporter;
    import fault_reporter_pkg::*;

`ifdef FAULT_REPORTER_CHECKSUM_EN
    localparam int REC_LEN = 7;
`else
    localparam int REC_LEN = 6;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        error = 1'b0;
    logic        id_opcode_decoding_error = 1'b0;
    logic [10:0] ex_errors = '0;
    logic [10:0] ex_opcode_selection = '0;
    logic [1:0]  current_pipeline_stage = '0;
    logic [31:0] pc = '0;
    logic        fault_clear = 1'b0;
    logic        halt;
    logic [7:0]  fault_cause;

    fault_reporter_if tx ();

    fault_reporter dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .error                    (error),
        .id_opcode_decoding_error (id_opcode_decoding_error),
        .ex_errors                (ex_errors),
        .ex_opcode_selection      (ex_opcode_selection),
        .current_pipeline_stage   (current_pipeline_stage),
        .pc                       (pc),
        .fault_clear              (fault_clear),
        .tx                       (tx.master),
        .halt                     (halt),
        .fault_cause              (fault_cause)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Push a record's bytes in wire order; checksum is the XOR of everything before it.
    task automatic push_record(input logic [7:0] b0, b1, b2, b3, b4, b5, input logic [7:0] csum);
        exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
        exp_q.push_back(b3); exp_q.push_back(b4); exp_q.push_back(b5);
`ifdef FAULT_REPORTER_CHECKSUM_EN
        exp_q.push_back(csum);
`else
        if (csum == 8'h00) exp_q.push_back(8'h00); // unreachable for the records used
`endif
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Advance until the record finishes; returns edges spent with tx_valid high.
    task automatic wait_record(input bit toggle_ready, output int cycles);
        cycles = 0;
        while (tx.tx_valid === 1'b1 && cycles < 100) begin
            step();
            cycles++;
            if (toggle_ready) tx.tx_ready = ~tx.tx_ready;
        end
        if (cycles >= 100) begin
            errors++;
            $display("FAIL record_timeout: tx_valid still %0b after %0d cycles", tx.tx_valid, cycles);
        end
        tx.tx_ready = 1'b1;
    endtask

    task automatic pulse_clear;
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        check("clear_halt", 32'(halt), 32'd0);
        check("clear_cause", 32'(fault_cause), 32'd0);
    endtask

    // Monitor: pop and compare on every accepted byte, and check hold-while-stalled.
    logic       stalled = 1'b0;
    logic [7:0] held = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", 32'(tx.tx_valid), 32'd1);
                check("hold_data", 32'(tx.tx_data), 32'(held));
            end
            if (tx.tx_valid === 1'b1 && tx.tx_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(tx.tx_data), 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", 32'(tx.tx_data), 32'(exp_q.pop_front()));
                end
            end
            stalled = (tx.tx_valid === 1'b1) && (tx.tx_ready !== 1'b1);
            held    = tx.tx_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int cyc;

    initial begin
        tx.tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_valid", 32'(tx.tx_valid), 32'd0);
        check("rst_cause", 32'(fault_cause), 32'd0);
        check("rst_data", 32'(tx.tx_data), 32'd0);
        rst_n = 1'b1;
        step();

        // Decode fault, ready held high: back-to-back bytes.
        current_pipeline_stage = 2'd2;
        id_opcode_decoding_error = 1'b1;
        pc = 32'h0000_0104;
        push_record(8'hFE, 8'h01, 8'h04, 8'h01, 8'h00, 8'h00, 8'hFA);
        step();
        id_opcode_decoding_error = 1'b0;
        current_pipeline_stage = 2'd0;
        check("dec_halt", 32'(halt), 32'd1);
        check("dec_cause", 32'(fault_cause), 32'h01);
        wait_record(1'b0, cyc);
        check("dec_len", 32'(cyc), 32'(REC_LEN));
        check("dec_drained", 32'(exp_q.size()), 32'd0);
        check("done_halt", 32'(halt), 32'd1);
        step();
        check("done_valid", 32'(tx.tx_valid), 32'd0);
        pulse_clear();

        // Execute fault at opcode 5 with ready toggling.
        current_pipeline_stage = 2'd3;
        ex_opcode_selection = 11'h020;
        ex_errors = 11'h020;
        pc = 32'hDEAD_BEEF;
        push_record(8'hFE, 8'h15, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hC9);
        step();
        ex_errors = '0;
        ex_opcode_selection = '0;
        current_pipeline_stage = 2'd0;
        check("exe_cause", 32'(fault_cause), 32'h15);
        wait_record(1'b1, cyc);
        check("exe_drained", 32'(exp_q.size()), 32'd0);
        pulse_clear();

        // Multiple opcodes selected outranks a stage-3 decode error.
        current_pipeline_stage = 2'd3;
        ex_opcode_selection = 11'h003;
        id_opcode_decoding_error = 1'b1;
        pc = 32'h0000_0010;
        push_record(8'hFE, 8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEC);
        step();
        ex_opcode_selection = '0;
        id_opcode_decoding_error = 1'b0;
        current_pipeline_stage = 2'd0;
        check("multi_cause", 32'(fault_cause), 32'h02);
        wait_record(1'b0, cyc);
        check("multi_drained", 32'(exp_q.size()), 32'd0);
        pulse_clear();

        // Unknown source; later faults and an early clear are ignored.
        error = 1'b1;
        pc = 32'h1234_5678;
        push_record(8'hFE, 8'hFF, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09);
        step();
        tx.tx_ready = 1'b0;
        current_pipeline_stage = 2'd2;
        id_opcode_decoding_error = 1'b1;
        fault_clear = 1'b1;
        step();
        current_pipeline_stage = 2'd0;
        id_opcode_decoding_error = 1'b0;
        fault_clear = 1'b0;
        tx.tx_ready = 1'b1;
        check("unk_cause_kept", 32'(fault_cause), 32'hFF);
        check("unk_still_valid", 32'(tx.tx_valid), 32'd1);
        wait_record(1'b0, cyc);
        check("unk_drained", 32'(exp_q.size()), 32'd0);
        pc = 32'h0000_0ABC;
        pulse_clear();
        // error still high after the clear: a fresh unknown record starts.
        push_record(8'hFE, 8'hFF, 8'hBC, 8'h0A, 8'h00, 8'h00, 8'hB7);
        step();
        error = 1'b0;
        check("rearm_halt", 32'(halt), 32'd1);
        check("rearm_cause", 32'(fault_cause), 32'hFF);
        wait_record(1'b0, cyc);
        check("rearm_drained", 32'(exp_q.size()), 32'd0);
        pulse_clear();

        // Reset mid-record drops valid immediately.
        tx.tx_ready = 1'b0;
        current_pipeline_stage = 2'd2;
        id_opcode_decoding_error = 1'b1;
        pc = 32'h0000_0200;
        push_record(8'hFE, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'hFD);
        step();
        id_opcode_decoding_error = 1'b0;
        current_pipeline_stage = 2'd0;
        step();
        check("pre_rst_valid", 32'(tx.tx_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(tx.tx_valid), 32'd0);
        check("mid_rst_halt", 32'(halt), 32'd0);
        exp_q.delete();
        tx.tx_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle", 32'(tx.tx_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
